servo_pwm_sequencer: RTL and testbench

APB3 slave in the FPGA fabric that drives the turret's two hobby-servo PWM lines (pan and tilt) from firmware-written target positions. Each frame, it slews each channel's commanded pulse width toward its target by a programmable step. The two pulses are staggered by half a frame to limit peak supply current. A per-frame interrupt lets the Cortex-M3 pace its aiming loop.

---
 rtl/servo_pwm_sequencer.sv | 163 ++++++++++++++++
 tb/tb_servo_pwm_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/servo_pwm_sequencer.sv
// APB3 slave generating two staggered hobby-servo PWM pulses (pan, tilt) whose
// widths slew once per frame toward firmware-written targets.
module servo_pwm_sequencer #(
  parameter int TICK_DIV  = 10,
  parameter int FRAME_US  = 20000,
  parameter int MIN_US    = 1000,
  parameter int MAX_US    = 2000,
  parameter int CENTER_US = 1500
) (
  input  logic        PCLK,
  input  logic        PRESETN,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [7:0]  PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic        PWM_PAN,
  output logic        PWM_TILT,
  output logic        FRAME_IRQ
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX  = PW'(TICK_DIV - 1);
  localparam logic [14:0]   US_MAX     = 15'(FRAME_US - 1);
  localparam logic [14:0]   US_HALF    = 15'(FRAME_US / 2);
  localparam logic [15:0]   MIN16      = 16'(MIN_US);
  localparam logic [15:0]   MAX16      = 16'(MAX_US);
  localparam logic [10:0]   CENTER11   = 11'(CENTER_US);

  logic [1:0]    ctrl_q, ctrl_d;
  logic [10:0]   tgt0_q, tgt0_d, tgt1_q, tgt1_d;
  logic [10:0]   step_q, step_d;
  logic [10:0]   cur0_q, cur0_d, cur1_q, cur1_d;
  logic          flag_q, flag_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [14:0]   us_q, us_d;
  logic          pan_q, pan_d, tilt_q, tilt_d;

  logic       wrEn, w1cFlag, en, tick, frameEdge;
  logic [2:0] regSel;
  logic       settled0, settled1;

  // Full 16-bit compare so out-of-range writes cannot alias into the 11-bit field.
  function automatic logic [10:0] clampTgt(input logic [15:0] v);
    if (v < MIN16)      return MIN16[10:0];
    else if (v > MAX16) return MAX16[10:0];
    else                return v[10:0];
  endfunction

  function automatic logic [10:0] slew(input logic [10:0] cur,
                                       input logic [10:0] tgt,
                                       input logic [10:0] step);
    logic signed [11:0] diff;
    logic [11:0]        mag;
    diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    mag  = diff[11] ? 12'(-diff) : 12'(diff);
    if (step == 11'd0 || mag <= {1'b0, step}) return tgt;
    else if (diff[11])                          return cur - step;
    else                                        return cur + step;
  endfunction

  assign wrEn      = PSEL & PENABLE & PWRITE;
  assign regSel    = PADDR[4:2];
  assign en        = ctrl_q[0];
  assign tick      = en && (presc_q == PRESC_MAX);
  assign frameEdge = tick && (us_q == US_MAX);
  assign settled0  = (cur0_q == tgt0_q);
  assign settled1  = (cur1_q == tgt1_q);

  // Register writes feed straight into the boundary update so a write landing
  // on the boundary edge is honoured by that edge's slew.
  always_comb begin
    ctrl_d  = ctrl_q;
    tgt0_d  = tgt0_q;
    tgt1_d  = tgt1_q;
    step_d  = step_q;
    w1cFlag = 1'b0;
    if (wrEn) begin
      case (regSel)
        3'd0:    ctrl_d  = PWDATA[1:0];
        3'd1:    tgt0_d  = clampTgt(PWDATA[15:0]);
        3'd2:    tgt1_d  = clampTgt(PWDATA[15:0]);
        3'd3:    step_d  = PWDATA[10:0];
        3'd6:    w1cFlag = PWDATA[2];
        default: ;
      endcase
    end

    presc_d = '0;
    us_d    = '0;
    if (en) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
      us_d    = tick ? ((us_q == US_MAX) ? 15'd0 : us_q + 15'd1) : us_q;
    end

    cur0_d = cur0_q;
    cur1_d = cur1_q;
    flag_d = w1cFlag ? 1'b0 : flag_q;
    if (frameEdge) begin
      cur0_d = slew(cur0_q, tgt0_d, step_d);
      cur1_d = slew(cur1_q, tgt1_d, step_d);
      flag_d = 1'b1;
    end

    pan_d  = en && (us_q < {4'b0, cur0_q});
    tilt_d = en && (us_q >= US_HALF) &&
             ({1'b0, us_q} < ({1'b0, US_HALF} + {5'b0, cur1_q}));
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      ctrl_q  <= 2'b00;
      tgt0_q  <= CENTER11;
      tgt1_q  <= CENTER11;
      step_q  <= 11'd0;
      cur0_q  <= CENTER11;
      cur1_q  <= CENTER11;
      flag_q  <= 1'b0;
      presc_q <= '0;
      us_q    <= 15'd0;
      pan_q   <= 1'b0;
      tilt_q  <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      tgt0_q  <= tgt0_d;
      tgt1_q  <= tgt1_d;
      step_q  <= step_d;
      cur0_q  <= cur0_d;
      cur1_q  <= cur1_d;
      flag_q  <= flag_d;
      presc_q <= presc_d;
      us_q    <= us_d;
      pan_q   <= pan_d;
      tilt_q  <= tilt_d;
    end
  end

  always_comb begin
    PRDATA = 32'd0;
    if (PSEL) begin
      case (regSel)
        3'd0:    PRDATA = {30'd0, ctrl_q};
        3'd1:    PRDATA = {21'd0, tgt0_q};
        3'd2:    PRDATA = {21'd0, tgt1_q};
        3'd3:    PRDATA = {21'd0, step_q};
        3'd4:    PRDATA = {21'd0, cur0_q};
        3'd5:    PRDATA = {21'd0, cur1_q};
        3'd6:    PRDATA = {29'd0, flag_q, settled1, settled0};
        default: PRDATA = 32'd0;
      endcase
    end
  end

  assign PREADY    = 1'b1;
  assign PSLVERR   = 1'b0;
  assign PWM_PAN   = pan_q;
  assign PWM_TILT  = tilt_q;
  assign FRAME_IRQ = flag_q & ctrl_q[1];

endmodule

// File: tb/tb_servo_pwm_sequencer.sv
// Directed bench for servo_pwm_sequencer using scaled-down timing parameters
// (2 PCLK per us, 500 us frame, 100..200 us pulse range) to keep runs short.
module tb_servo_pwm_sequencer;

  localparam int TB_TICK   = 2;
  localparam int TB_FRAME  = 500;
  localparam int TB_MIN    = 100;
  localparam int TB_MAX    = 200;
  localparam int TB_CENTER = 150;
  localparam int FRAME_CYC = TB_TICK * TB_FRAME;

  logic        pclk = 1'b0;
  logic        presetn;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [7:0]  paddr = 8'd0;
  logic [31:0] pwdata = 32'd0;
  logic [31:0] prdata;
  logic        pready, pslverr, pwmPan, pwmTilt, frameIrq;

  int assertCount = 0;
  int failCount   = 0;
  int cyc         = 0;
  int enCyc       = 0;

  servo_pwm_sequencer #(
    .TICK_DIV(TB_TICK), .FRAME_US(TB_FRAME), .MIN_US(TB_MIN),
    .MAX_US(TB_MAX), .CENTER_US(TB_CENTER)
  ) dut (
    .PCLK(pclk), .PRESETN(presetn), .PSEL(psel), .PENABLE(penable),
    .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata),
    .PREADY(pready), .PSLVERR(pslverr), .PWM_PAN(pwmPan),
    .PWM_TILT(pwmTilt), .FRAME_IRQ(frameIrq)
  );

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // APB write; returns 1 ns after the edge that commits the write.
  task automatic applyStimulus(input logic [7:0] addr, input logic [31:0] data);
    @(negedge pclk);
    psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = addr; pwdata = data;
    @(negedge pclk);
    penable = 1'b1;
    @(posedge pclk);
    #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apbRead(input logic [7:0] addr, output logic [31:0] data);
    @(negedge pclk);
    psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = addr;
    @(negedge pclk);
    penable = 1'b1;
    #1;
    data = prdata;
    @(posedge pclk);
    #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic checkRead(input string tag, input logic [7:0] addr,
                           input logic [31:0] expected);
    logic [31:0] d;
    apbRead(addr, d);
    checkOutput(tag, d, expected);
  endtask

  task automatic waitIrq(input int limit, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(posedge pclk);
      #1;
      if (frameIrq) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic waitPanHigh(input int limit, output logic seen);
    seen = pwmPan;
    for (int i = 0; i < limit && !seen; i++) begin
      @(posedge pclk);
      #1;
      seen = pwmPan;
    end
  endtask

  initial begin
    logic seen;
    int   highCount;
    int   panRise, panFall, tiltRise, tiltFall;
    logic prevPan, prevTilt;
    int   target;

    presetn = 1'b0;
    #2;
    checkOutput("rst_pan", {31'd0, pwmPan}, 32'd0);
    checkOutput("rst_tilt", {31'd0, pwmTilt}, 32'd0);
    checkOutput("rst_irq", {31'd0, frameIrq}, 32'd0);
    repeat (3) @(negedge pclk);
    presetn = 1'b1;

    checkOutput("pready", {31'd0, pready}, 32'd1);
    checkOutput("pslverr", {31'd0, pslverr}, 32'd0);
    checkRead("rst_ctrl", 8'h00, 32'd0);
    checkRead("rst_tgt0", 8'h04, 32'd150);
    checkRead("rst_tgt1", 8'h08, 32'd150);
    checkRead("rst_step", 8'h0C, 32'd0);
    checkRead("rst_cur0", 8'h10, 32'd150);
    checkRead("rst_cur1", 8'h14, 32'd150);
    checkRead("rst_status", 8'h18, 32'd3);
    checkRead("unmapped", 8'h1C, 32'd0);

    // Two idle frames with EN=0 must produce no pulses.
    highCount = 0;
    for (int i = 0; i < 2 * FRAME_CYC; i++) begin
      @(posedge pclk);
      #1;
      if (pwmPan || pwmTilt) highCount++;
    end
    checkOutput("idle_pwm_highs", highCount, 32'd0);

    // Target clamping, including values that would alias if truncated to 11 bits.
    applyStimulus(8'h04, 32'd3000);
    checkRead("clamp_hi", 8'h04, 32'd200);
    applyStimulus(8'h04, 32'd50);
    checkRead("clamp_lo", 8'h04, 32'd100);
    applyStimulus(8'h04, 32'h0000_0896);
    checkRead("clamp_noalias", 8'h04, 32'd200);
    applyStimulus(8'h04, 32'h0001_0096);
    checkRead("clamp_upper_ignored", 8'h04, 32'd150);

    // Jump with STEP=0: pan target 180 us.
    applyStimulus(8'h04, 32'd180);
    applyStimulus(8'h00, 32'd3);
    enCyc = cyc;
    waitIrq(FRAME_CYC + 200, seen);
    checkOutput("jump_irq_seen", {31'd0, seen}, 32'd1);
    checkOutput("jump_boundary_cyc", cyc - enCyc, FRAME_CYC);

    panRise = -1; panFall = -1; tiltRise = -1; tiltFall = -1;
    prevPan = pwmPan; prevTilt = pwmTilt;
    checkOutput("pan_low_on_boundary", {31'd0, pwmPan}, 32'd0);
    for (int t = 1; t <= 900; t++) begin
      @(posedge pclk);
      #1;
      if (pwmPan && !prevPan && panRise < 0) panRise = t;
      if (!pwmPan && prevPan && panFall < 0) panFall = t;
      if (pwmTilt && !prevTilt && tiltRise < 0) tiltRise = t;
      if (!pwmTilt && prevTilt && tiltFall < 0) tiltFall = t;
      prevPan = pwmPan; prevTilt = pwmTilt;
    end
    checkOutput("pan_rise_lag", panRise, 32'd1);
    checkOutput("pan_width", panFall - panRise, 32'd360);
    checkOutput("tilt_offset", tiltRise - panRise, 32'd500);
    checkOutput("tilt_width", tiltFall - tiltRise, 32'd300);

    applyStimulus(8'h18, 32'd4);
    checkOutput("irq_cleared", {31'd0, frameIrq}, 32'd0);
    checkRead("jump_status", 8'h18, 32'd3);
    checkRead("jump_cur0", 8'h10, 32'd180);

    // Slew tilt 150 -> 200 in steps of 10.
    applyStimulus(8'h0C, 32'd10);
    applyStimulus(8'h08, 32'd200);
    for (int k = 1; k <= 5; k++) begin
      waitIrq(FRAME_CYC + 200, seen);
      checkOutput($sformatf("slew_irq_seen_%0d", k), {31'd0, seen}, 32'd1);
      checkOutput($sformatf("slew_phase_%0d", k), (cyc - enCyc) % FRAME_CYC, 32'd0);
      checkRead($sformatf("slew_cur1_%0d", k), 8'h14, 150 + 10 * k);
      checkRead($sformatf("slew_status_%0d", k), 8'h18,
                (k == 5) ? 32'd7 : 32'd5);
      applyStimulus(8'h18, 32'd4);
    end

    // W1C landing on the same edge as a boundary: set must win.
    target = enCyc + FRAME_CYC * ((cyc - enCyc) / FRAME_CYC + 1);
    if (target - 2 <= cyc) target += FRAME_CYC;
    while (cyc < target - 2) begin
      @(posedge pclk);
      #1;
    end
    applyStimulus(8'h18, 32'd4);
    checkOutput("coincide_irq", {31'd0, frameIrq}, 32'd1);
    checkRead("coincide_status", 8'h18, 32'd7);
    applyStimulus(8'h00, 32'd1);
    checkOutput("irq_masked", {31'd0, frameIrq}, 32'd0);

    // Disable in the middle of a pan pulse.
    waitPanHigh(FRAME_CYC + 200, seen);
    checkOutput("pan_seen_before_disable", {31'd0, seen}, 32'd1);
    applyStimulus(8'h00, 32'd0);
    checkOutput("pan_on_disable_edge", {31'd0, pwmPan}, 32'd1);
    @(posedge pclk);
    #1;
    checkOutput("pan_after_disable", {31'd0, pwmPan}, 32'd0);
    applyStimulus(8'h04, 32'd100);
    highCount = 0;
    for (int i = 0; i < 1500; i++) begin
      @(posedge pclk);
      #1;
      if (pwmPan || pwmTilt) highCount++;
    end
    checkOutput("disabled_pwm_highs", highCount, 32'd0);
    checkRead("frozen_cur0", 8'h10, 32'd180);
    checkRead("frozen_status", 8'h18, 32'd6);

    // Re-enable: counting restarts from us 0, first update one frame later.
    applyStimulus(8'h18, 32'd4);
    applyStimulus(8'h00, 32'd3);
    enCyc = cyc;
    waitIrq(FRAME_CYC + 200, seen);
    checkOutput("reen_irq_seen", {31'd0, seen}, 32'd1);
    checkOutput("reen_boundary_cyc", cyc - enCyc, FRAME_CYC);
    checkRead("reen_cur0", 8'h10, 32'd170);

    // Asynchronous reset during a pulse with the interrupt pending.
    waitPanHigh(FRAME_CYC + 200, seen);
    checkOutput("pan_seen_before_reset", {31'd0, seen}, 32'd1);
    checkOutput("irq_before_reset", {31'd0, frameIrq}, 32'd1);
    #3;
    presetn = 1'b0;
    #1;
    checkOutput("areset_pan", {31'd0, pwmPan}, 32'd0);
    checkOutput("areset_tilt", {31'd0, pwmTilt}, 32'd0);
    checkOutput("areset_irq", {31'd0, frameIrq}, 32'd0);
    @(negedge pclk);
    presetn = 1'b1;
    checkRead("post_rst_cur0", 8'h10, 32'd150);
    checkRead("post_rst_tgt0", 8'h04, 32'd150);
    checkRead("post_rst_ctrl", 8'h00, 32'd0);
    checkRead("post_rst_status", 8'h18, 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
